// File: rtl/noc_params.sv
// Shared NoC definitions used by packet_sender and packet_receiver.
// Holds the packet geometry, the packed packet layout, the byte-link framing
// constants and the receiver state encoding, so both ends of the link agree
// on them.
package noc_params;

  // Packet geometry: destination coordinates followed by the payload.
  localparam int X_DEST_W       = 4;
  localparam int Y_DEST_W       = 4;
  localparam int PAYLOAD_W      = 24;
  localparam int PKT_SIZE       = X_DEST_W + Y_DEST_W + PAYLOAD_W;
  localparam int PKT_SIZE_BYTES = PKT_SIZE / 8;

  // Field order matches the byte order on the link: x_dest is in the first byte.
  typedef struct packed {
    logic [X_DEST_W-1:0]  x_dest;
    logic [Y_DEST_W-1:0]  y_dest;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

  // Byte-link framing: frames are delimited by FRAME_DELIM. A data byte that
  // collides with either control byte is sent as FRAME_ESC, byte ^ ESC_XOR.
  localparam logic [7:0] FRAME_DELIM = 8'h7E;
  localparam logic [7:0] FRAME_ESC   = 8'h7D;
  localparam logic [7:0] ESC_XOR     = 8'h20;

  // Receiver deframer states.
  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_ESC  = 2'd2
  } recv_state_t;

  // True for data bytes that must be escaped by the sender.
  function automatic logic needs_escape(input logic [7:0] b);
    return (b == FRAME_DELIM) || (b == FRAME_ESC);
  endfunction

endpackage

// File: rtl/packet_receiver.sv
// packet_receiver: serial deframer for the NoC byte link.
// Hunts for the start delimiter, removes escapes, collects PKT_SIZE_BYTES
// data bytes MSB-first and checks the closing delimiter. A good frame updates
// pkt with a one-cycle valid_out pulse; any framing fault gives a one-cycle
// frame_err pulse and bumps a saturating error counter. The deframer always
// resynchronises on its own.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   valid_in   rx_byte is valid this cycle (gaps allowed)
//   rx_byte    byte from the link
//   pkt        last correctly received packet, held until the next one
//   valid_out  one-cycle pulse when pkt updates
//   frame_err  one-cycle pulse on any framing fault
//   err_count  saturating count of frame_err pulses
module packet_receiver
  import noc_params::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [7:0]           rx_byte,
  output packet_t              pkt,
  output logic                 valid_out,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // byte_cnt must be able to hold the full byte count itself, not just
  // count below it.
  localparam int CNT_W = $clog2(PKT_SIZE_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_SIZE_BYTES);

  recv_state_t         state, state_next;
  logic [CNT_W-1:0]    byte_cnt, cnt_next;
  logic [PKT_SIZE-1:0] shift_reg, shift_next;
  logic                load_pkt;
  logic                raise_err;
  logic                is_delim;
  logic                is_esc;

  // Delimiter classification uses the raw byte, before any unescape.
  assign is_delim = (rx_byte == FRAME_DELIM);
  assign is_esc   = (rx_byte == FRAME_ESC);

  // Deframer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HUNT;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      byte_cnt  <= cnt_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic. Only cycles with valid_in advance the deframer; a
  // fault that sees a delimiter treats it as the start of a new frame so a
  // damaged frame costs at most one packet.
  always_comb begin
    state_next = state;
    cnt_next   = byte_cnt;
    shift_next = shift_reg;
    load_pkt   = 1'b0;
    raise_err  = 1'b0;

    if (valid_in) begin
      case (state)
        S_HUNT: begin
          if (is_delim) begin
            state_next = S_DATA;
            cnt_next   = '0;
          end
        end

        S_DATA: begin
          if (is_delim) begin
            if (byte_cnt == CNT_FULL) begin
              load_pkt   = 1'b1;
              state_next = S_HUNT;
            end else if (byte_cnt != '0) begin
              // Short frame: this delimiter opens the next frame.
              raise_err = 1'b1;
            end
            if (byte_cnt != CNT_FULL) begin
              cnt_next = '0;
            end
          end else if (is_esc) begin
            if (byte_cnt == CNT_FULL) begin
              raise_err  = 1'b1;
              state_next = S_HUNT;
            end else begin
              state_next = S_ESC;
            end
          end else begin
            if (byte_cnt == CNT_FULL) begin
              // Overlength frame.
              raise_err  = 1'b1;
              state_next = S_HUNT;
            end else begin
              shift_next = {shift_reg[PKT_SIZE-9:0], rx_byte};
              cnt_next   = byte_cnt + 1'b1;
            end
          end
        end

        S_ESC: begin
          // S_ESC is only entered with room for one more byte.
          if (is_delim) begin
            raise_err  = 1'b1;
            state_next = S_DATA;
            cnt_next   = '0;
          end else begin
            shift_next = {shift_reg[PKT_SIZE-9:0], rx_byte ^ ESC_XOR};
            cnt_next   = byte_cnt + 1'b1;
            state_next = S_DATA;
          end
        end

        default: begin
          state_next = S_HUNT;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Registered outputs: pkt only moves on a good frame, so a failed frame
  // leaves the previous packet visible. The counter updates on the same edge
  // that raises frame_err and sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt       <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      valid_out <= load_pkt;
      frame_err <= raise_err;
      if (load_pkt) begin
        pkt <= shift_reg;
      end
      if (raise_err && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver.
// Directed steps run in one initial block; every expected packet is pushed
// to a scoreboard queue when its frame is driven and popped by a monitor when
// valid_out pulses. The monitor also counts frame_err pulses for comparison
// with the bench's own expected fault count.
module tb_packet_receiver;
  import noc_params::*;

  localparam int ERR_CNT_W = 8;

  logic                 clk;
  logic                 rst;
  logic                 valid_in;
  logic [7:0]           rx_byte;
  packet_t              pkt;
  logic                 valid_out;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_count;

  int          tests_run;
  int          fails;
  int          err_pulses;
  int          exp_err_pulses;
  logic [31:0] exp_q[$];
  logic [31:0] last_pkt;

  packet_receiver #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .rx_byte   (rx_byte),
    .pkt       (pkt),
    .valid_out (valid_out),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one byte for one cycle, optionally preceded by idle cycles that
  // carry junk on rx_byte.
  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        valid_in = 1'b0;
        rx_byte  = 8'($urandom);
      end
    end
    @(negedge clk);
    valid_in = 1'b1;
    rx_byte  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // Reference encoder (what packet_sender puts on the link) plus the
  // scoreboard push of the packet the receiver must produce.
  task automatic sendFrame(input logic [31:0] p, input bit gaps);
    logic [7:0] b;
    exp_q.push_back(p);
    applyStimulus(FRAME_DELIM, gaps);
    for (int i = 3; i >= 0; i--) begin
      b = p[i*8 +: 8];
      if (needs_escape(b)) begin
        applyStimulus(FRAME_ESC, gaps);
        applyStimulus(b ^ ESC_XOR, gaps);
      end else begin
        applyStimulus(b, gaps);
      end
    end
    applyStimulus(FRAME_DELIM, gaps);
  endtask

  function automatic logic [7:0] randByte();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return FRAME_DELIM;
    if (r == 1) return FRAME_ESC;
    return 8'($urandom);
  endfunction

  function automatic logic [63:0] expCount(input int pulses);
    return (pulses > 255) ? 64'd255 : 64'(pulses);
  endfunction

  // Monitor: sample away from the active edge, pop and compare on valid_out.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid_out", 64'(pkt), 64'hx);
        end else begin
          checkOutput("pkt", 64'(pkt), 64'(exp_q.pop_front()));
        end
      end
      if (frame_err) err_pulses++;
    end
  end

  // End-of-step check: scoreboard drained, fault count and counter as modelled.
  task automatic checkStep(input string tag);
    idle(3);
    checkOutput({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    checkOutput({tag, "_err_pulses"}, 64'(err_pulses), 64'(exp_err_pulses));
    checkOutput({tag, "_err_count"}, 64'(err_count), expCount(exp_err_pulses));
  endtask

  initial begin
    logic [31:0] p;
    tests_run      = 0;
    fails          = 0;
    err_pulses     = 0;
    exp_err_pulses = 0;
    rst            = 1'b1;
    valid_in       = 1'b0;
    rx_byte        = 8'h00;

    repeat (2) @(negedge clk);
    checkOutput("reset_pkt", 64'(pkt), 64'd0);
    checkOutput("reset_valid_out", 64'(valid_out), 64'd0);
    checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
    checkOutput("reset_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;

    // Plain frame.
    sendFrame(32'h12345678, 1'b0);
    checkStep("plain");
    checkOutput("plain_x_dest", 64'(pkt.x_dest), 64'h1);
    checkOutput("plain_y_dest", 64'(pkt.y_dest), 64'h2);
    checkOutput("plain_payload", 64'(pkt.payload), 64'h345678);

    // Escapes, written out byte by byte.
    exp_q.push_back(32'h7E7D0001);
    applyStimulus(8'h7E, 1'b0); applyStimulus(8'h7D, 1'b0);
    applyStimulus(8'h5E, 1'b0); applyStimulus(8'h7D, 1'b0);
    applyStimulus(8'h5D, 1'b0); applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0); applyStimulus(8'h7E, 1'b0);
    checkStep("escape");
    checkOutput("escape_x_dest", 64'(pkt.x_dest), 64'h7);
    checkOutput("escape_y_dest", 64'(pkt.y_dest), 64'hE);

    // Garbage, doubled delimiter, gaps inside the data.
    exp_q.push_back(32'h11223344);
    applyStimulus(8'hAA, 1'b0); applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h7E, 1'b0); applyStimulus(8'h7E, 1'b0);
    applyStimulus(8'h11, 1'b1); applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1); applyStimulus(8'h44, 1'b1);
    applyStimulus(8'h7E, 1'b1);
    checkStep("gaps");

    // Short frame, then recovery on the delimiter that cut it short.
    applyStimulus(8'h7E, 1'b0); applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0); applyStimulus(8'h7E, 1'b0);
    exp_err_pulses++;
    idle(2);
    checkOutput("short_pkt_held", 64'(pkt), 64'h11223344);
    exp_q.push_back(32'hA1A2A3A4);
    applyStimulus(8'hA1, 1'b0); applyStimulus(8'hA2, 1'b0);
    applyStimulus(8'hA3, 1'b0); applyStimulus(8'hA4, 1'b0);
    applyStimulus(8'h7E, 1'b0);
    checkStep("short");

    // Overlength frame, then escape followed by a delimiter.
    applyStimulus(8'h7E, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0);
    applyStimulus(8'h7E, 1'b0);
    exp_err_pulses++;
    idle(2);
    checkOutput("overlen_pkt_held", 64'(pkt), 64'hA1A2A3A4);
    checkOutput("overlen_err_count", 64'(err_count), expCount(exp_err_pulses));
    applyStimulus(8'h7E, 1'b0); applyStimulus(8'h7D, 1'b0);
    applyStimulus(8'h7E, 1'b0);
    exp_err_pulses++;
    idle(2);
    checkOutput("esc_err_pkt_held", 64'(pkt), 64'hA1A2A3A4);
    exp_q.push_back(32'h01020304);
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
    applyStimulus(8'h7E, 1'b0);
    checkStep("overlen_esc");

    // Reset in the middle of a frame.
    applyStimulus(8'h7E, 1'b0); applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("midrst_pkt", 64'(pkt), 64'd0);
    checkOutput("midrst_valid_out", 64'(valid_out), 64'd0);
    checkOutput("midrst_frame_err", 64'(frame_err), 64'd0);
    checkOutput("midrst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    rst            = 1'b0;
    err_pulses     = 0;
    exp_err_pulses = 0;
    // The rest of the interrupted frame is discarded while hunting; the
    // closing 7E opens a new frame and must not emit anything.
    applyStimulus(8'h03, 1'b0); applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h7E, 1'b0);
    checkStep("midrst");
    checkOutput("midrst_pkt_after", 64'(pkt), 64'd0);

    // 300 short frames saturate the counter.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h7E, 1'b0);
      exp_err_pulses++;
    end
    checkStep("saturate");
    checkOutput("saturate_value", 64'(err_count), 64'd255);

    // Fresh start, then random packets through the reference encoder.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst            = 1'b0;
    err_pulses     = 0;
    exp_err_pulses = 0;
    last_pkt       = 32'h0;
    for (int i = 0; i < 1000; i++) begin
      p = {randByte(), randByte(), randByte(), randByte()};
      last_pkt = p;
      sendFrame(p, ($urandom_range(0, 3) == 0));
    end
    checkStep("loopback");
    checkOutput("loopback_last_pkt", 64'(pkt), 64'(last_pkt));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
